// File: rtl/cgra_cmem_loader.sv
// Copies a block of words from system memory (OBI read master) into the CGRA
// context memory, one read outstanding at a time.
module cgra_cmem_loader #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] src_addr_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [CNT_WIDTH-1:0]  n_words_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  aborted_o,
   output logic [CNT_WIDTH-1:0]  words_done_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  cm_req_o,
   output logic [ADDR_WIDTH-1:0] cm_add_o,
   output logic                  cm_we_o,
   output logic [3:0]            cm_be_o,
   output logic [DATA_WIDTH-1:0] cm_wdata_o,
   input  logic                  cm_gnt_i
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE} state_e;

   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_WIDTH-1:0]  remaining_q, words_done_q;
   logic                  abort_q, aborted_q;
   logic                  abort_eff;

   // An abort arriving in the deciding cycle takes effect immediately.
   assign abort_eff = abort_q | abort_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = (n_words_i == '0) ? DONE : RD_REQ;
         RD_REQ:  if (mem_gnt_i) state_d = RD_WAIT;
         RD_WAIT: if (mem_rvalid_i) state_d = abort_eff ? DONE : WR;
         WR: begin
            if (cm_gnt_i) begin
               state_d = (remaining_q == CNT_WIDTH'(1) || abort_eff) ? DONE : RD_REQ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o    = (state_q != IDLE);
      done_o    = (state_q == DONE);
      mem_req_o = (state_q == RD_REQ);
      cm_req_o  = (state_q == WR);
      cm_we_o   = (state_q == WR);
      aborted_o = (state_q == DONE) ? abort_q : aborted_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q        <= '0;
         dst_q        <= '0;
         data_q       <= '0;
         remaining_q  <= '0;
         words_done_q <= '0;
         abort_q      <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  src_q        <= src_addr_i & WORD_MASK;
                  dst_q        <= dst_addr_i & WORD_MASK;
                  remaining_q  <= n_words_i;
                  words_done_q <= '0;
                  aborted_q    <= 1'b0;
               end
            end
            RD_WAIT: if (mem_rvalid_i) data_q <= mem_rdata_i;
            WR: begin
               if (cm_gnt_i) begin
                  words_done_q <= words_done_q + CNT_WIDTH'(1);
                  remaining_q  <= remaining_q - CNT_WIDTH'(1);
                  src_q        <= src_q + WORD_STEP;
                  dst_q        <= dst_q + WORD_STEP;
               end
            end
            DONE:    aborted_q <= abort_q;
            default: ;
         endcase
         // Abort is only recorded while a transfer is in flight.
         if (state_q == DONE) begin
            abort_q <= 1'b0;
         end else if (state_q != IDLE && abort_i) begin
            abort_q <= 1'b1;
         end
      end
   end

   assign words_done_o = words_done_q;
   assign mem_addr_o   = src_q;
   assign cm_add_o     = dst_q;
   assign cm_wdata_o   = data_q;
   assign cm_be_o      = 4'hF;

endmodule

// File: doc/cgra_cmem_loader.md
Name: cgra_cmem_loader

Overview:
Upstream feeder of the CGRA context-memory decoder. It copies a block of 32-bit words from system memory into the context-memory slave port, which covers instruction banks and kernel-configuration registers. It reads through an OBI-style master port, one read outstanding at a time. Each returned word is written to the context-memory request port at consecutive word addresses. Software programs the source, destination and length, then pulses start_i.

Parameters:
ADDR_WIDTH, 32, byte-address width of both the OBI read port and the context-memory port
DATA_WIDTH, 32, data word width (fixed at 32; be is 4 bits)
CNT_WIDTH, 10, width of the word-count and progress counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  single-cycle start pulse; honoured only in IDLE
abort_i  in  1  request early termination; sticky until the transfer ends
src_addr_i  in  ADDR_WIDTH  source byte address (word-aligned, bits[1:0] ignored)
dst_addr_i  in  ADDR_WIDTH  context-memory byte address (word-aligned, bits[1:0] ignored)
n_words_i  in  CNT_WIDTH  number of words to copy
busy_o  out  1  high while the FSM is not IDLE
done_o  out  1  one-cycle pulse at the end of a transfer
aborted_o  out  1  set with done_o if the transfer was aborted; held until the next accepted start
words_done_o  out  CNT_WIDTH  words written in the current or last transfer
mem_req_o  out  1  OBI read request
mem_addr_o  out  ADDR_WIDTH  OBI read address
mem_gnt_i  in  1  OBI grant
mem_rvalid_i  in  1  OBI read data valid
mem_rdata_i  in  DATA_WIDTH  OBI read data
cm_req_o  out  1  context-memory request
cm_add_o  out  ADDR_WIDTH  context-memory byte address
cm_we_o  out  1  write enable; always 1 while cm_req_o is high
cm_be_o  out  4  byte enables; constant 4'hF
cm_wdata_o  out  DATA_WIDTH  write data
cm_gnt_i  in  1  context-memory grant

Behaviour:
- Reset values: all outputs 0 except cm_be_o=4'hF. FSM=IDLE. All counters, address registers and the abort flag are cleared.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- IDLE, start_i=1:
  - latch src/dst with bits[1:0] forced to 0, latch n_words_i as remaining, clear words_done_o and aborted_o.
  - if n_words_i==0, go to DONE; otherwise go to RD_REQ.
- RD_REQ:
  - mem_req_o=1, mem_addr_o=src register.
  - mem_req_o and mem_addr_o stay stable until mem_gnt_i. On gnt, go to RD_WAIT.
  - mem_req_o deasserts the cycle after gnt; a request is never withdrawn before gnt.
- RD_WAIT:
  - on mem_rvalid_i, capture mem_rdata_i into the data register.
  - if the abort flag is set, discard the data and go to DONE; otherwise go to WR.
  - mem_rvalid_i arriving in the same cycle as gnt is not legal OBI and need not be handled.
- WR:
  - cm_req_o=1, cm_we_o=1, cm_add_o=dst register, cm_wdata_o=data register; all held stable until cm_gnt_i.
  - on gnt: words_done+1, remaining-1, src+4, dst+4.
  - if remaining was 1 or the abort flag is set, go to DONE; otherwise go to RD_REQ.
- DONE: done_o=1 for exactly one cycle; aborted_o = abort flag; clear the abort flag; return to IDLE.
- Throughput: with a zero-wait slave, one word per 3 cycles (RD_REQ, RD_WAIT, WR), plus one DONE cycle per transfer.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Abort:
  - abort_i in IDLE or DONE is ignored.
  - abort_i in any other state sets the abort flag. The in-flight bus transaction always completes; a pending OBI read is completed and its data dropped.
  - abort_i and the final cm_gnt_i in the same cycle: the word counts, and aborted_o=1.
- start_i while busy_o=1 is ignored and does not alter the latched parameters.
- Reset mid-transfer returns everything to reset values in the same cycle it is asserted. No done_o is generated.

Test Plan:
- Basic copy:
  - stimulus: src=0x1000, dst=0x0000_0040, n=3; memory holds 0xA0,0xA1,0xA2; both slaves grant immediately.
  - response: three cm writes at 0x40, 0x44, 0x48 with those data; done_o pulses once; words_done_o=3; busy_o high for exactly 3*3+1=10 cycles.
- Zero length:
  - stimulus: n=0.
  - response: no mem_req_o or cm_req_o; done_o one cycle after start; aborted_o=0.
- Backpressure:
  - stimulus: mem_gnt_i delayed 4 cycles; cm_gnt_i delayed 2 cycles; n=2.
  - response: req, address and data stay stable while waiting; exactly 2 OBI grants and 2 cm writes.
- Abort during RD_WAIT:
  - stimulus: n=5; abort_i pulsed while waiting for the 2nd word's rvalid.
  - response: 2nd data is not written; words_done_o=1; done_o with aborted_o=1.
- Unaligned addresses and start while busy:
  - stimulus: src=0x1003, dst=0x0041 (ignored bits); a start_i pulse mid-transfer carrying different parameters.
  - response: accesses go to 0x1000 and 0x40; the second start has no effect.
- Reset mid-transfer:
  - stimulus: rst_ni low during WR.
  - response: cm_req_o=0 and busy_o=0 immediately; no done_o; a new start after reset completes normally.
